// File: rtl/ring_nic.sv
// Network interface between a PE and one gold_ring router port: a single-entry
// outbound buffer feeding the router and a single-entry inbound capture buffer.
module ring_nic #(
    parameter int DATA_WIDTH = 64,
    parameter int VC_BIT     = 63
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nic_en,
    input  logic                  nic_wr_en,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di
);

    logic [DATA_WIDTH-1:0] out_buf_q, out_buf_d;
    logic                  out_full_q, out_full_d;
    logic [DATA_WIDTH-1:0] in_buf_q, in_buf_d;
    logic                  in_full_q, in_full_d;

    logic [3:0] sel;
    logic       pe_rd;
    logic       pe_wr;
    logic       in_capture;
    logic       in_release;
    logic       out_load;
    logic       out_send;

    for (genvar gi = 0; gi < 4; gi++) begin : g_addr_dec
        assign sel[gi] = (addr == 2'(gi));
    end

    assign pe_rd = nic_en & ~nic_wr_en;
    assign pe_wr = nic_en & nic_wr_en;

    // The router may only hand us a packet while the inbound slot is free.
    assign net_ri     = ~in_full_q;
    assign in_capture = net_si & net_ri;
    assign in_release = pe_rd & sel[0] & in_full_q;

    // A packet is offered only when its VC matches the ring's current polarity.
    assign net_do   = out_buf_q;
    assign net_so   = out_full_q & (out_buf_q[VC_BIT] == net_polarity);
    assign out_send = net_so & net_ro;
    assign out_load = pe_wr & sel[2] & ~out_full_q;

    always_comb begin
        d_out = '0;
        if (pe_rd) begin
            case (addr)
                2'd0:    d_out = in_buf_q;
                2'd1:    d_out = DATA_WIDTH'(in_full_q);
                2'd3:    d_out = DATA_WIDTH'(out_full_q);
                default: d_out = '0;
            endcase
        end
    end

    // Capture and release are mutually exclusive: one needs the slot empty, the other full.
    always_comb begin
        in_buf_d  = in_buf_q;
        in_full_d = in_full_q;
        if (in_capture) begin
            in_buf_d  = net_di;
            in_full_d = 1'b1;
        end else if (in_release) begin
            in_full_d = 1'b0;
        end
    end

    // A write landing in the drain cycle sees out_full=1 and is dropped.
    always_comb begin
        out_buf_d  = out_buf_q;
        out_full_d = out_full_q;
        if (out_send) begin
            out_full_d = 1'b0;
        end else if (out_load) begin
            out_buf_d  = d_in;
            out_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_buf_q  <= '0;
            out_full_q <= 1'b0;
            in_buf_q   <= '0;
            in_full_q  <= 1'b0;
        end else begin
            out_buf_q  <= out_buf_d;
            out_full_q <= out_full_d;
            in_buf_q   <= in_buf_d;
            in_full_q  <= in_full_d;
        end
    end

endmodule

// File: tb/tb_ring_nic.sv
// Bench for ring_nic: directed vector table for the scripted scenarios, then
// random traffic checked against a packet-level reference model.
module tb_ring_nic;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    addr;
    logic [DW-1:0] d_in;
    logic [DW-1:0] d_out;
    logic          nic_en;
    logic          nic_wr_en;
    logic          net_so;
    logic          net_ro;
    logic [DW-1:0] net_do;
    logic          net_polarity;
    logic          net_si;
    logic          net_ri;
    logic [DW-1:0] net_di;

    int n_checks = 0;
    int n_fail   = 0;

    ring_nic #(.DATA_WIDTH(DW), .VC_BIT(63)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nic_en(nic_en), .nic_wr_en(nic_wr_en), .net_so(net_so), .net_ro(net_ro),
        .net_do(net_do), .net_polarity(net_polarity), .net_si(net_si),
        .net_ri(net_ri), .net_di(net_di)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, en, we;
        bit [1:0]    a;
        bit [DW-1:0] din;
        bit          ro, pol, si;
        bit [DW-1:0] di;
        bit          chk;
        bit [DW-1:0] e_dout;
        bit          e_so, e_ri;
        bit [DW-1:0] e_do;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit rst, bit en, bit we, bit [1:0] a, bit [DW-1:0] din,
                                bit ro, bit pol, bit si, bit [DW-1:0] di, bit chk,
                                bit [DW-1:0] e_dout, bit e_so, bit e_ri, bit [DW-1:0] e_do);
        vec_t v;
        v.rst = rst; v.en = en; v.we = we; v.a = a; v.din = din;
        v.ro = ro; v.pol = pol; v.si = si; v.di = di; v.chk = chk;
        v.e_dout = e_dout; v.e_so = e_so; v.e_ri = e_ri; v.e_do = e_do;
        vt.push_back(v);
    endfunction

    task automatic check(string name, int idx, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(bit rst, bit en, bit we, bit [1:0] a, bit [DW-1:0] din,
                         bit ro, bit pol, bit si, bit [DW-1:0] di);
        reset = rst; nic_en = en; nic_wr_en = we; addr = a; d_in = din;
        net_ro = ro; net_polarity = pol; net_si = si; net_di = di;
    endtask

    localparam logic [DW-1:0] PK_A  = 64'h8000_0000_0000_00AA;
    localparam logic [DW-1:0] PK_B  = 64'h0000_1234_5678_9ABC;
    localparam logic [DW-1:0] PK_C  = 64'hDEAD_BEEF_0000_0001;
    localparam logic [DW-1:0] PK_D  = 64'h0000_0000_0000_0055;
    localparam logic [DW-1:0] PK_E  = 64'h8000_0000_0000_0077;
    localparam logic [DW-1:0] PK_F  = 64'h0000_0000_0000_0F0F;

    // Reference model state, updated from the spec rules at each clock edge.
    logic [DW-1:0] m_out_buf, m_in_buf;
    bit            m_out_full, m_in_full;
    logic [DW-1:0] sent_q[$];

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);

        // rst en we a din ro pol si di chk | dout so ri do
        add(1,0,0,0,0,    0,0,0,0,    0, 0,0,1,0);
        add(1,0,0,0,0,    0,0,0,0,    1, 0,0,1,0);
        add(0,1,0,1,0,    0,0,0,0,    1, 0,0,1,0);
        add(0,1,0,3,0,    0,0,0,0,    1, 0,0,1,0);
        // Outbound VC=1 packet is offered only on polarity-1 cycles.
        add(0,1,1,2,PK_A, 1,1,0,0,    1, 0,0,1,0);
        add(0,0,0,0,0,    1,0,0,0,    1, 0,0,1,PK_A);
        add(0,1,0,3,0,    1,1,0,0,    1, 1,1,1,PK_A);
        add(0,1,0,3,0,    1,0,0,0,    1, 0,0,1,PK_A);
        add(0,1,0,3,0,    1,1,0,0,    1, 0,0,1,PK_A);
        // Inbound capture and readback.
        add(0,0,0,0,0,    0,0,1,PK_B, 1, 0,0,1,PK_A);
        add(0,1,0,1,0,    0,0,0,0,    1, 1,0,0,PK_A);
        // Second packet held off while full, captured after the clearing read.
        add(0,1,0,1,0,    0,0,1,PK_C, 1, 1,0,0,PK_A);
        add(0,1,0,0,0,    0,0,1,PK_C, 1, PK_B,0,0,PK_A);
        add(0,0,0,0,0,    0,0,1,PK_C, 1, 0,0,1,PK_A);
        add(0,1,0,0,0,    0,0,0,0,    1, PK_C,0,0,PK_A);
        add(0,1,0,0,0,    0,0,0,0,    1, PK_C,0,1,PK_A);
        // Dropped writes while full, including the drain cycle.
        add(0,1,1,2,PK_D, 0,0,0,0,    1, 0,0,1,PK_A);
        add(0,0,0,0,0,    0,0,0,0,    1, 0,1,1,PK_D);
        add(0,1,1,2,64'h1,0,1,0,0,    1, 0,0,1,PK_D);
        add(0,1,0,3,0,    0,0,0,0,    1, 1,1,1,PK_D);
        add(0,1,1,2,64'h2,1,0,0,0,    1, 0,1,1,PK_D);
        add(0,1,0,3,0,    1,0,0,0,    1, 0,0,1,PK_D);
        // Reset with both buffers full.
        add(0,1,1,2,PK_E, 0,0,1,PK_F, 1, 0,0,1,PK_D);
        add(0,1,0,1,0,    0,1,0,0,    1, 1,1,0,PK_E);
        add(1,0,0,0,0,    0,1,0,0,    1, 0,1,0,PK_E);
        add(0,1,0,3,0,    0,1,0,0,    1, 0,0,1,0);
        add(0,1,0,1,0,    0,1,0,0,    1, 0,0,1,0);
        add(0,1,0,0,0,    0,1,0,0,    1, 0,0,1,0);

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].rst, vt[i].en, vt[i].we, vt[i].a, vt[i].din,
                  vt[i].ro, vt[i].pol, vt[i].si, vt[i].di);
            #1;
            if (vt[i].chk) begin
                check("d_out",  i, d_out,        vt[i].e_dout);
                check("net_so", i, DW'(net_so),  DW'(vt[i].e_so));
                check("net_ri", i, DW'(net_ri),  DW'(vt[i].e_ri));
                check("net_do", i, net_do,       vt[i].e_do);
            end
            $display("vec %0d rst=%0b en=%0b we=%0b a=%0d d_out=%h so=%0b ri=%0b do=%h",
                     i, vt[i].rst, vt[i].en, vt[i].we, vt[i].a, d_out, net_so, net_ri, net_do);
        end

        // Random phase; the model starts from a forced reset cycle.
        m_out_buf = '0; m_in_buf = '0; m_out_full = 0; m_in_full = 0;
        for (int c = 0; c < 600; c++) begin
            bit            r_rst, r_en, r_we, r_ro, r_pol, r_si;
            bit [1:0]      r_a;
            logic [DW-1:0] r_din, r_di, e_dout;
            bit            e_so, e_ri, pe_rd, pe_wr;
            r_rst = (c == 0) || ($urandom_range(0, 59) == 0);
            r_en  = $urandom_range(0, 1);
            r_we  = $urandom_range(0, 1);
            r_a   = 2'($urandom_range(0, 3));
            r_din = {32'($urandom), 32'($urandom)};
            r_ro  = $urandom_range(0, 3) != 0;
            r_pol = $urandom_range(0, 1);
            r_si  = $urandom_range(0, 1);
            r_di  = {32'($urandom), 32'($urandom)};
            @(negedge clk);
            drive(r_rst, r_en, r_we, r_a, r_din, r_ro, r_pol, r_si, r_di);
            #1;
            pe_rd  = r_en && !r_we;
            pe_wr  = r_en && r_we;
            e_ri   = !m_in_full;
            e_so   = m_out_full && (m_out_buf[63] == r_pol);
            e_dout = '0;
            if (pe_rd && r_a == 0) e_dout = m_in_buf;
            if (pe_rd && r_a == 1) e_dout = DW'(m_in_full);
            if (pe_rd && r_a == 3) e_dout = DW'(m_out_full);
            if (c > 0) begin
                check("rnd_d_out",  c, d_out,       e_dout);
                check("rnd_net_so", c, DW'(net_so), DW'(e_so));
                check("rnd_net_ri", c, DW'(net_ri), DW'(e_ri));
                check("rnd_net_do", c, net_do,      m_out_buf);
            end
            if (r_rst) begin
                m_out_buf = '0; m_in_buf = '0; m_out_full = 0; m_in_full = 0;
                sent_q.delete();
            end else begin
                if (r_si && !m_in_full) begin
                    m_in_buf = r_di; m_in_full = 1;
                end else if (pe_rd && r_a == 0 && m_in_full) begin
                    m_in_full = 0;
                end
                if (e_so && r_ro) begin
                    if (sent_q.size() == 0) check("rnd_send_order", c, net_do, '1);
                    else check("rnd_send_order", c, net_do, sent_q.pop_front());
                    m_out_full = 0;
                end else if (pe_wr && r_a == 2 && !m_out_full) begin
                    m_out_buf = r_din; m_out_full = 1;
                    sent_q.push_back(r_din);
                end
            end
            $display("rnd %0d rst=%0b en=%0b we=%0b a=%0d so=%0b ri=%0b d_out=%h",
                     c, r_rst, r_en, r_we, r_a, net_so, net_ri, d_out);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
